// File: rtl/bridge_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// bridge_buffer_ctrl
//
// Sequences a dual-port word buffer between a linear-projection producer and a
// systolic-array consumer. The controller fills a tile of TOTAL_DEPTH words
// through port A. It then drains the tile through port B. Each stored word is
// presented as TOTAL_MODULES consecutive slices, and the downstream slice mux
// picks the current slice using slicing_idx.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst          : synchronous active-high reset
//   in_valid     : producer word present on buffer din
//   in_ready     : controller accepts a write this cycle (FILL only)
//   out_ready    : systolic array accepts the current slice
//   out_valid    : buffer dout slice is valid (STREAM only)
//   clear        : synchronous abort of the current tile
//   ena/wea      : buffer port-A enable / write enable
//   enb          : buffer port-B enable (one-cycle read issue)
//   addra/addrb  : buffer write / read address
//   slicing_idx  : slice select for the registered read word
//   tile_done    : one-cycle pulse at the end of a tile drain
// -----------------------------------------------------------------------------
module bridge_buffer_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int TOTAL_DEPTH   = 12,
  parameter int TOTAL_MODULES = 4,
  localparam int SLICE_W      = $clog2(TOTAL_MODULES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  input  logic                  clear,
  output logic                  ena,
  output logic                  wea,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [SLICE_W-1:0]    slicing_idx,
  output logic                  tile_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [SLICE_W-1:0]    LAST_SLICE = SLICE_W'(TOTAL_MODULES - 1);
  localparam logic [SLICE_W-1:0]    SLICE_ONE  = SLICE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_PRIME  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [SLICE_W-1:0]      slice_q, slice_d;

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
      slice_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_addr_q <= rd_addr_d;
      slice_q   <= slice_d;
    end
  end

  // Next-state and counter update; clear overrides any handshake this cycle
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_addr_d = rd_addr_q;
    slice_d   = slice_q;
    if (clear) begin
      state_d   = S_FILL;
      wr_cnt_d  = '0;
      rd_addr_d = '0;
      slice_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
        end
        S_FILL: begin
          if (in_valid) begin
            if (wr_cnt_q == LAST_ADDR) begin
              wr_cnt_d  = '0;
              rd_addr_d = '0;
              state_d   = S_PRIME;
            end else begin
              wr_cnt_d = wr_cnt_q + ADDR_ONE;
            end
          end else begin
            state_d = S_FILL;
          end
        end
        // One-cycle read latency: the word registered here is held in STREAM
        S_PRIME: begin
          state_d = S_STREAM;
        end
        S_STREAM: begin
          if (out_ready) begin
            if (slice_q == LAST_SLICE) begin
              slice_d = '0;
              if (rd_addr_q == LAST_ADDR) begin
                state_d = S_DONE;
              end else begin
                rd_addr_d = rd_addr_q + ADDR_ONE;
                state_d   = S_PRIME;
              end
            end else begin
              slice_d = slice_q + SLICE_ONE;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
        S_DONE: begin
          state_d = S_FILL;
        end
        default: begin
          state_d   = S_IDLE;
          wr_cnt_d  = '0;
          rd_addr_d = '0;
          slice_d   = '0;
        end
      endcase
    end
  end

  // Output decode: strobes follow the state directly, so the buffer sees the
  // write enable in the same cycle as the handshake. A write or end-of-tile
  // pulse coinciding with clear is suppressed because that tile is discarded.
  // Reset forces every output low, even before the state register has settled.
  always_comb begin
    in_ready    = 1'b0;
    ena         = 1'b0;
    wea         = 1'b0;
    enb         = 1'b0;
    out_valid   = 1'b0;
    tile_done   = 1'b0;
    addra       = '0;
    addrb       = '0;
    slicing_idx = '0;
    if (rst) begin
      in_ready    = 1'b0;
      ena         = 1'b0;
      wea         = 1'b0;
      enb         = 1'b0;
      out_valid   = 1'b0;
      tile_done   = 1'b0;
      addra       = '0;
      addrb       = '0;
      slicing_idx = '0;
    end else begin
      in_ready    = (state_q == S_FILL);
      ena         = (state_q == S_FILL) && in_valid && !clear;
      wea         = (state_q == S_FILL) && in_valid && !clear;
      enb         = (state_q == S_PRIME);
      out_valid   = (state_q == S_STREAM);
      tile_done   = (state_q == S_DONE) && !clear;
      addra       = wr_cnt_q;
      addrb       = rd_addr_q;
      slicing_idx = slice_q;
    end
  end

endmodule

// File: doc/bridge_buffer_ctrl.md
BRIDGE_BUFFER_CTRL -- requirements
Module: bridge_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the buffer port-A/port-B address width.
REQ-002 SHALL have parameter TOTAL_DEPTH, default 12, meaning the number of words written per tile; legal range 2..2^ADDR_WIDTH.
REQ-003 SHALL have parameter TOTAL_MODULES, default 4, meaning the number of slices read out per stored word; legal range 2..256.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the linear-projection word is present on the buffer din.
REQ-007 SHALL have port in_ready, output, 1 bit: the controller accepts a write this cycle.
REQ-008 SHALL have port out_ready, input, 1 bit: the systolic array accepts the current slice.
REQ-009 SHALL have port out_valid, output, 1 bit: the buffer dout slice is valid.
REQ-010 SHALL have port clear, input, 1 bit: synchronous abort of the current tile.
REQ-011 SHALL have ports ena, wea and enb, outputs, 1 bit each: buffer port-A enable, port-A write enable and port-B enable.
REQ-012 SHALL have ports addra and addrb, outputs, ADDR_WIDTH bits each: buffer write and read addresses.
REQ-013 SHALL have port slicing_idx, output, clog2(TOTAL_MODULES) bits: selects the slice of the registered read word.
REQ-014 SHALL have port tile_done, output, 1 bit: one-cycle pulse marking the end of a tile drain.

Function
REQ-015 SHALL implement the states IDLE, FILL, PRIME, STREAM and DONE.
REQ-016 IDLE SHALL transition to FILL unconditionally on the next cycle.
REQ-017 In FILL, in_ready SHALL be 1 and a write SHALL occur when in_valid and in_ready are both high.
REQ-018 During a write, ena and wea SHALL be 1 (combinational) and addra SHALL equal wr_cnt; wr_cnt SHALL then increment.
REQ-019 A write with wr_cnt equal to TOTAL_DEPTH-1 SHALL clear wr_cnt and rd_addr and move to PRIME; in_ready SHALL be 0 in every state other than FILL.
REQ-020 In PRIME, enb SHALL be 1 and addrb SHALL equal rd_addr; the state SHALL move to STREAM next cycle (buffer read latency is 1).
REQ-021 In STREAM, out_valid SHALL be 1, enb SHALL be 0 so the buffer holds dout, and addrb SHALL hold rd_addr.
REQ-022 A beat SHALL be out_valid and out_ready both high; each beat SHALL increment slicing_idx, and with out_ready low all outputs SHALL hold.
REQ-023 On a beat with slicing_idx at TOTAL_MODULES-1, slicing_idx SHALL wrap to 0; if rd_addr is below TOTAL_DEPTH-1, rd_addr SHALL increment and the state SHALL move to PRIME, otherwise to DONE.
REQ-024 DONE SHALL assert tile_done for exactly 1 cycle and then move to FILL.
REQ-025 With continuous handshakes, the first out_valid SHALL occur 2 cycles after the last write; a drain SHALL take TOTAL_DEPTH*(TOTAL_MODULES+1)+1 cycles.
REQ-026 clear in any state SHALL zero wr_cnt, rd_addr and slicing_idx and move to FILL next cycle, with no tile_done.
REQ-027 If clear and a handshake occur in the same cycle, clear SHALL win and that write or beat SHALL be discarded.
REQ-028 ena, wea, enb and out_valid SHALL never be 1 in the same cycle as in_ready is 1 in a non-FILL state.
REQ-029 All counters SHALL saturate-free wrap within their widths; no address SHALL ever reach TOTAL_DEPTH.

Reset
REQ-030 When rst is high, state SHALL become IDLE and all counters 0.
REQ-031 While rst is high, in_ready, ena, wea, enb, out_valid and tile_done SHALL be 0, and addra, addrb and slicing_idx SHALL be 0.
REQ-032 rst asserted mid-tile SHALL discard the tile; the block SHALL return to IDLE, then FILL in the cycle after rst deasserts.

Verification
REQ-033 Reset then 12 consecutive in_valid -> addra 0..11 with wea high; PRIME 1 cycle after the last write; out_valid 2 cycles after it.
REQ-034 out_ready held 1 -> addrb 0..11, each giving slicing_idx 0,1,2,3; tile_done pulses once; the drain takes 61 cycles.
REQ-035 out_ready toggled 1,0 during STREAM -> slicing_idx and addrb hold on low cycles; no slice is skipped or repeated.
REQ-036 in_valid gapped (1,0,1,...) in FILL -> wr_cnt advances only on high cycles; 12 writes are required before PRIME.
REQ-037 clear at rd_addr 5 with slicing_idx 2, with out_ready also 1 -> next cycle FILL, in_ready 1, counters 0, no tile_done.
REQ-038 rst pulsed during FILL at wr_cnt 7 -> outputs 0 during rst; IDLE then FILL; the next write uses addra 0.
